uart_im_loader: RTL

Boot-time program loader that receives an instruction image over the board UART pin and writes it word by word into the instruction memory's write port (the port the SoC top otherwise ties to `4'b0000`). It holds the CPU in reset while loading, releases it when a complete, checked image has been written, and latches an error code otherwise. It sits at the SoC top between `uart_rxd`, the IM write port and the CPU reset.

---
 rtl/uart_im_loader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/uart_im_loader.sv
// uart_im_loader: UART boot loader writing a length-prefixed word image into IM, holding the CPU until done.
// Optional trailing XOR checksum byte enabled by LOADER_CHECKSUM_EN.
module uart_im_loader #(
  parameter int CLK_DIV = 217,
  parameter int ADDR_W  = 12
) (
  input  logic              clk,
  input  logic              sys_rstn,
  input  logic              uart_rxd,
  output logic [3:0]        im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code,
  output logic [15:0]       word_cnt
);
  localparam int CW = $clog2(CLK_DIV);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_t;
  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR} fs_t;
`ifdef LOADER_CHECKSUM_EN
  localparam fs_t FIN = S_CHK;
`else
  localparam fs_t FIN = S_DONE;
`endif
  logic [2:0] sync_q;
  rx_t rs_q, rs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  fs_t fs_q, fs_d;
  logic [15:0] len_q, len_d, wc_q, wc_d;
  logic [1:0] idx_q, idx_d, ec_q, ec_d;
  logic [23:0] wbuf_q, wbuf_d;
  logic [7:0] chk_q, chk_d;
  logic we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic rx, half, full, byte_valid, frame_err;
  logic [15:0] n;
  always_ff @(posedge clk) begin
    if (!sys_rstn) begin
      sync_q <= '1;
      rs_q <= R_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      fs_q <= S_LEN0;
      len_q <= '0;
      wc_q <= '0;
      idx_q <= '0;
      ec_q <= '0;
      wbuf_q <= '0;
      chk_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], uart_rxd};
      rs_q <= rs_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      fs_q <= fs_d;
      len_q <= len_d;
      wc_q <= wc_d;
      idx_q <= idx_d;
      ec_q <= ec_d;
      wbuf_q <= wbuf_d;
      chk_q <= chk_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  assign rx = sync_q[1];
  assign half = cnt_q == CW'(CLK_DIV / 2 - 1);
  assign full = cnt_q == CW'(CLK_DIV - 1);
  always_comb begin
    rs_d = rs_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d = sh_q;
    case (rs_q)
      R_IDLE: begin
        cnt_d = '0;
        if (sync_q[2] && !rx) rs_d = R_START;
      end
      R_START: if (half) begin
        cnt_d = '0;
        bit_d = '0;
        rs_d = rx ? R_IDLE : R_DATA;
      end
      R_DATA: if (full) begin
        cnt_d = '0;
        sh_d = {rx, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) rs_d = R_STOP;
      end
      default: if (full) begin
        cnt_d = '0;
        rs_d = R_IDLE;
      end
    endcase
  end
  assign byte_valid = rs_q == R_STOP && full && rx;
  assign frame_err = rs_q == R_STOP && full && !rx;
  assign n = {sh_q, len_q[7:0]};
  // Completion waits until the last word's write has been issued (word_cnt caught up with N)
  always_comb begin
    fs_d = fs_q;
    if (frame_err && fs_q inside {S_LEN0, S_LEN1, S_DATA, S_CHK}) fs_d = S_ERR;
    else case (fs_q)
      S_LEN0: if (byte_valid) fs_d = S_LEN1;
      S_LEN1: if (byte_valid) fs_d = ({1'b0, n} > 17'(1 << ADDR_W)) ? S_ERR : (n == 16'd0) ? FIN : S_DATA;
      S_DATA: if (wc_q == len_q) fs_d = FIN;
      S_CHK: if (byte_valid) fs_d = (sh_q == chk_q) ? S_DONE : S_ERR;
      default: ;
    endcase
  end
  always_comb begin
    len_d = len_q;
    idx_d = idx_q;
    wbuf_d = wbuf_q;
    chk_d = chk_q;
    wc_d = wc_q;
    we_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    ec_d = ec_q;
    if (byte_valid && fs_q inside {S_LEN0, S_LEN1, S_DATA}) chk_d = chk_q ^ sh_q;
    if (byte_valid && fs_q == S_LEN0) len_d[7:0] = sh_q;
    if (byte_valid && fs_q == S_LEN1) len_d[15:8] = sh_q;
    if (byte_valid && fs_q == S_DATA) begin
      idx_d = idx_q + 1'b1;
      wbuf_d = {sh_q, wbuf_q[23:8]};
      if (idx_q == 2'd3) begin
        we_d = 1'b1;
        addr_d = wc_q[ADDR_W-1:0];
        wdata_d = {sh_q, wbuf_q};
        wc_d = wc_q + 1'b1;
      end
    end
    if (fs_d == S_ERR && fs_q != S_ERR) ec_d = frame_err ? 2'b01 : (fs_q == S_LEN1) ? 2'b11 : 2'b10;
  end
  assign im_we = {4{we_q}};
  assign im_addr = addr_q;
  assign im_wdata = wdata_q;
  assign word_cnt = wc_q;
  assign load_done = fs_q == S_DONE;
  assign load_err = fs_q == S_ERR;
  assign cpu_hold = fs_q != S_DONE;
  assign err_code = ec_q;
endmodule
